// File: rtl/muldiv_unit_if.sv
// EX-stage <-> RV32M execute unit handshake bundle.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            kill;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1_val, rs2_val, kill,
        input  busy, result_valid, result
    );

    modport slave (
        input  start, op, rs1_val, rs2_val, kill,
        output busy, result_valid, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: shift-add multiply and restoring divide,
// one bit per cycle, with a single-cycle path for divide-by-zero/overflow.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN)
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);

    if (XLEN != 32) begin : g_xlen_check
        $error("muldiv_unit: only XLEN=32 is supported");
    end

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   acc_hi;    // mul: running upper product; div: remainder
    logic [XLEN-1:0]   acc_lo;    // mul: multiplier/lower product; div: dividend/quotient
    logic [XLEN-1:0]   opb;       // mul: multiplicand; div: divisor (magnitudes)
    logic              is_div;
    logic              sel_hi;    // mul: take high word; div: take remainder
    logic              neg_res;   // sign of the selected result
    logic [XLEN-1:0]   result_q;

    logic              a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              in_div, in_hi, in_neg, fast_path;
    logic [XLEN-1:0]   fast_res;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   nxt_hi, nxt_lo, div_pick;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fin_res;

    // Operand decode at accept: signedness, magnitudes, result sign, fast path.
    always_comb begin
        a_signed  = (!bus.op[2] && bus.op[1:0] != 2'b11) || (bus.op[2] && !bus.op[0]);
        b_signed  = (!bus.op[2] && !bus.op[1]) || (bus.op[2] && !bus.op[0]);
        sign_a    = a_signed && bus.rs1_val[XLEN-1];
        sign_b    = b_signed && bus.rs2_val[XLEN-1];
        abs_a     = sign_a ? -bus.rs1_val : bus.rs1_val;
        abs_b     = sign_b ? -bus.rs2_val : bus.rs2_val;
        in_div    = bus.op[2];
        in_hi     = in_div ? bus.op[1] : (bus.op[1:0] != 2'b00);
        in_neg    = (in_div && bus.op[1]) ? sign_a : (sign_a ^ sign_b);
        fast_path = 1'b0;
        fast_res  = '0;
        if (in_div && bus.rs2_val == '0) begin
            fast_path = 1'b1;
            fast_res  = bus.op[1] ? bus.rs1_val : '1;
        end else if (in_div && !bus.op[0] && bus.rs1_val == MIN_NEG && bus.rs2_val == '1) begin
            fast_path = 1'b1;
            fast_res  = bus.op[1] ? '0 : MIN_NEG;
        end
    end

    // One multiply or divide iteration plus the sign-corrected final result.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb};
        if (is_div) begin
            nxt_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            nxt_lo = {acc_lo[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            nxt_hi = mul_sum[XLEN:1];
            nxt_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
        // Multiply negates the full 64-bit product so the high word is correct.
        prod_fix = neg_res ? -{nxt_hi, nxt_lo} : {nxt_hi, nxt_lo};
        div_pick = sel_hi ? nxt_hi : nxt_lo;
        if (is_div) begin
            fin_res = neg_res ? -div_pick : div_pick;
        end else begin
            fin_res = sel_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            is_div   <= 1'b0;
            sel_hi   <= 1'b0;
            neg_res  <= 1'b0;
            result_q <= '0;
        end else if (bus.kill) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        is_div  <= in_div;
                        sel_hi  <= in_hi;
                        neg_res <= in_neg;
                        opb     <= abs_b;
                        if (fast_path) begin
                            result_q <= fast_res;
                            state    <= DONE;
                        end else begin
                            acc_hi <= '0;
                            acc_lo <= abs_a;
                            cnt    <= CNT_W'(XLEN - 1);
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result_q <= fin_res;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // busy must rise in the accept cycle itself so the hazard unit stalls at once.
    assign bus.busy         = !rst && !bus.kill &&
                              ((state == IDLE && bus.start) || state == CALC);
    assign bus.result_valid = !rst && !bus.kill && (state == DONE);
    assign bus.result       = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors, expected results queued
// at issue and checked by an independent monitor when result_valid appears.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] res;
        int unsigned due;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    // Cycle index used for all latency expectations.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got result %h expected no result_valid (cycle %0d)",
                         bus.result, cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, " result"}, bus.result, e.res);
                check({e.name, " valid_cycle"}, cyc, e.due);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle; start stays high while stalled and
    // operands are scrambled after accept. Returns in the cycle after DONE.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit fast,
                          input bit hold, input bit chk_zero);
        int unsigned lat;
        lat = fast ? 1 : 33;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs1_val = a;
        bus.rs2_val = b;
        sb.push_back('{exp, cyc + lat, name});
        @(negedge clk);
        check({name, " busy_accept"}, {31'b0, bus.busy}, 32'd1);
        if (chk_zero) begin
            check({name, " result_after_rst"}, bus.result, 32'd0);
            check({name, " valid_after_rst"}, {31'b0, bus.result_valid}, 32'd0);
        end
        for (int unsigned k = 1; k < lat; k++) begin
            step();
            bus.op      = op ^ 3'b001;
            bus.rs1_val = ~a;
            bus.rs2_val = b + 32'd1;
            @(negedge clk);
            check({name, " busy_calc"}, {31'b0, bus.busy}, 32'd1);
        end
        step();
        if (!hold) bus.start = 1'b0;
        @(negedge clk);
        check({name, " busy_done"}, {31'b0, bus.busy}, 32'd0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b1;
        bus.kill    = 1'b0;
        bus.op      = 3'b000;
        bus.rs1_val = 32'd0;
        bus.rs2_val = 32'd0;
        step();
        step();
        @(negedge clk);
        check("rst busy", {31'b0, bus.busy}, 32'd0);
        check("rst valid", {31'b0, bus.result_valid}, 32'd0);
        step();
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("idle result", bus.result, 32'd0);
        check("idle busy", {31'b0, bus.busy}, 32'd0);
        step();

        // Multiply family
        run_op("MUL",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, 0, 0);
        run_op("MULH",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 0, 0, 0);
        run_op("MULHSU", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
        run_op("MULHU",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0);
        // Divide family
        run_op("DIV",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 0, 0);
        run_op("REM",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 0, 0);
        run_op("DIVU",   3'b101, 32'd100,      32'd7,        32'd14,       0, 0, 0);
        run_op("REMU",   3'b111, 32'd100,      32'd7,        32'd2,        0, 0, 0);
        // Fast path
        run_op("DIV_BY0",  3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0, 0);
        run_op("REMU_BY0", 3'b111, 32'd5,        32'd0,        32'd5,        1, 0, 0);
        run_op("DIV_OVF",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, 0);
        run_op("REM_OVF",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0, 0);

        // kill at cycle 10 of a DIVU, then MUL accepted in cycle 11
        bus.start   = 1'b1;
        bus.op      = 3'b101;
        bus.rs1_val = 32'd1000;
        bus.rs2_val = 32'd3;
        for (int unsigned k = 0; k < 10; k++) begin
            if (k > 0) step();
            @(negedge clk);
            check("KILL busy_pre", {31'b0, bus.busy}, 32'd1);
        end
        step();
        bus.kill = 1'b1;
        @(negedge clk);
        check("KILL busy", {31'b0, bus.busy}, 32'd0);
        check("KILL valid", {31'b0, bus.result_valid}, 32'd0);
        step();
        bus.kill = 1'b0;
        run_op("MUL_AFTER_KILL", 3'b000, 32'd3, 32'd5, 32'd15, 0, 0, 0);

        // Same recovery through rst at cycle 10
        bus.start   = 1'b1;
        bus.op      = 3'b101;
        bus.rs1_val = 32'd1000;
        bus.rs2_val = 32'd3;
        for (int unsigned k = 0; k < 10; k++) begin
            if (k > 0) step();
            @(negedge clk);
            check("RSTK busy_pre", {31'b0, bus.busy}, 32'd1);
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        check("RSTK busy", {31'b0, bus.busy}, 32'd0);
        check("RSTK valid", {31'b0, bus.result_valid}, 32'd0);
        step();
        rst = 1'b0;
        run_op("MUL_AFTER_RST", 3'b000, 32'd6, 32'd7, 32'd42, 0, 0, 1);

        // Back-to-back with start held through DONE
        run_op("B2B_MUL",  3'b000, 32'h12345678, 32'h10, 32'h23456780, 0, 1, 0);
        run_op("B2B_DIVU", 3'b101, 32'd1000,     32'd10, 32'd100,      0, 0, 0);

        repeat (5) step();
        check("scoreboard_drain", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M execute unit in the EX stage of the 5-stage pipeline.
- Accepts one M-extension operation from the EX stage and drives muldiv_busy to the hazard unit, which freezes IF/ID/EX while busy is high.
- Returns a 32-bit result in the cycle busy drops, so the stalled EX instruction advances with its result.
- Shift-add multiply and restoring divide, one bit per cycle; trivial divide cases take a 1-cycle fast path.

Parameters:
- XLEN, 32, operand/result width; only 32 supported; any other value is an elaboration error.
- CNT_W, $clog2(XLEN), iteration counter width (derived, do not override).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- start  in  1  EX holds a valid M-op; held high while stalled
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_val  in  32  forwarded operand A
- rs2_val  in  32  forwarded operand B
- kill  in  1  abort in-flight op (trap/interrupt)
- busy  out  1  to hazard unit muldiv_busy
- result_valid  out  1  result present this cycle
- result  out  32  rd write data

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (rst). Any cycle with rst=1 forces state IDLE next edge; counter, accumulators, result and result_valid clear to 0. busy is 0 while rst=1.
- States: IDLE, CALC, DONE.
- IDLE, accept (start=1, kill=0):
  - latch op and operands; take absolute values per signedness (MULH: both signed; MULHSU: A signed, B unsigned; MULHU/DIVU/REMU: unsigned); record result sign.
  - busy=1 combinationally in the accept cycle, so the hazard unit stalls immediately.
- IDLE, fast path (divide ops only), goes straight to DONE:
  - B==0: quotient 0xFFFFFFFF, remainder = A (raw, unsigned view).
  - signed DIV/REM with A==0x80000000 and B==0xFFFFFFFF: quotient 0x80000000, remainder 0.
- IDLE, other ops: go to CALC with counter = 31.
- CALC:
  - one iteration per cycle (multiply: 64-bit shift-add; divide: restoring subtract-shift).
  - busy=1; counter decrements; on counter==0 go to DONE.
- DONE:
  - result register holds the final value, with sign correction (two's-complement negate) applied when entering DONE.
  - MUL takes low 32 bits; MULH/MULHSU/MULHU take high 32 bits; remainder sign follows dividend, quotient sign = sign A xor sign B.
  - result_valid=1, busy=0; next state IDLE unconditionally.
  - start still high in DONE belongs to the completing instruction and is ignored.
- Latency, with accept in cycle 0:
  - iterative ops: CALC cycles 1..32, DONE (result_valid) cycle 33.
  - fast path: DONE in cycle 1.
  - busy high in cycles 0..32 (iterative) or cycle 0 (fast).
- Back-to-back: a new start in the IDLE cycle after DONE is accepted normally. No op is accepted in DONE.
- kill:
  - in any state, forces busy=0 and result_valid=0 combinationally and state IDLE next edge; no result is produced.
  - kill together with start in IDLE: not accepted.
- Operands are sampled only at accept; changes to rs1_val/rs2_val/op afterwards are ignored.
- result holds its last value outside DONE. Consumers qualify it with result_valid.

Test Plan:
- MUL 7 * 0xFFFFFFFD accepted cycle 0 -> busy high cycles 0..32, result_valid cycle 33 only, result 0xFFFFFFEB; busy=0 in cycle 33.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; all valid at cycle 33.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; valid at cycle 33.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; each busy only cycle 0, valid cycle 1.
- kill at cycle 10 of a DIVU -> busy 0 in cycle 10, no result_valid ever; new MUL accepted cycle 11 -> valid cycle 44. Repeat with rst=1 at cycle 10 -> same recovery, all outputs 0 next cycle.
- Back-to-back: MUL then DIVU with start held through DONE -> second accept in cycle 34 (not 33), valid at 67; exactly one result_valid pulse per op.
